// File: rtl/chandelier_pkg.sv
// Shared definitions for the chandelier bulb sensing and brightness blocks.
package chandelier_pkg;

   localparam int NUM_BULBS = 4;
   localparam int SEL_W     = 2;
   localparam int RUN_W     = 3;
   localparam int CNT_W     = 4;

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_SAMPLE = 1'b1
   } scan_state_e;

   // Bit i high means bulb i is working.
   typedef logic [NUM_BULBS-1:0] bulb_status_t;

   // Round-robin bulb index; the width makes 3 wrap to 0.
   function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
      return sel + 1'b1;
   endfunction

endpackage

// File: rtl/bulb_debounce.sv
// Per-bulb debounce: counts consecutive samples that disagree with the
// published status and flips the status once the run reaches its threshold.
module bulb_debounce
   import chandelier_pkg::*;
#(
   parameter int unsigned FAIL_CNT    = 3,
   parameter int unsigned RECOVER_CNT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_i,
   input  logic value_i,
   output logic status_o,
   output logic fall_o
);

   localparam logic [RUN_W-1:0] FAIL_THR    = RUN_W'(FAIL_CNT);
   localparam logic [RUN_W-1:0] RECOVER_THR = RUN_W'(RECOVER_CNT);

   logic [RUN_W-1:0] run_q, run_d;
   logic             status_q, status_d;
   logic             fall_q, fall_d;
   logic [RUN_W-1:0] thr;
   logic [RUN_W-1:0] run_inc;

   // Threshold depends on which direction a change would go.
   always_comb begin
      thr     = status_q ? FAIL_THR : RECOVER_THR;
      run_inc = run_q + 1'b1;
   end

   // Next-state for the run counter, status bit and fall pulse.
   always_comb begin
      run_d    = run_q;
      status_d = status_q;
      fall_d   = 1'b0;
      if (sample_i) begin
         if (value_i == status_q) begin
            run_d = '0;
         end else if (run_inc >= thr) begin
            status_d = ~status_q;
            run_d    = '0;
            fall_d   = status_q;
         end else begin
            run_d = run_inc;
         end
      end
   end

   // State registers; bulbs start out assumed working.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q    <= '0;
         status_q <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         run_q    <= run_d;
         status_q <= status_d;
         fall_q   <= fall_d;
      end
   end

   assign status_o = status_q;
   assign fall_o   = fall_q;

endmodule

// File: rtl/bulb_health_monitor.sv
// Time-multiplexed bulb current sensing: synchronizes the shared comparator,
// scans the bulbs round-robin and publishes debounced per-bulb status.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SETTLE | bulb sense_sel routed, waiting SETTLE_CYC cycles to settle
// ST_SAMPLE | one cycle: sense_s is consumed for bulb sense_sel
module bulb_health_monitor
   import chandelier_pkg::*;
#(
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned FAIL_CNT    = 3,
   parameter int unsigned RECOVER_CNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sense_ok,
   output logic [SEL_W-1:0] sense_sel,
   output bulb_status_t     bulb_status,
   output logic             status_valid,
   output logic             fault_pulse
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic             sync1_q;
   logic             sense_s_q;
   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;

   logic [NUM_BULBS-1:0] strobe;
   logic [NUM_BULBS-1:0] fall_vec;
   bulb_status_t         status_vec;

   // Two-flop synchronizer; sense_ok is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sense_s_q <= 1'b0;
      end else begin
         sync1_q   <= sense_ok;
         sense_s_q <= sync1_q;
      end
   end

   // Scan FSM next-state: settle count, bulb index and first-scan flag.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      sel_d        = sel_q;
      valid_d      = valid_q;
      case (state_q)
         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            sel_d        = next_sel(sel_q);
            if (sel_q == SEL_W'(NUM_BULBS - 1)) begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
         end
      endcase
   end

   // Scan FSM registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_SETTLE;
         settle_cnt_q <= '0;
         sel_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         sel_q        <= sel_d;
         valid_q      <= valid_d;
      end
   end

   // Only the selected bulb sees the sample strobe.
   always_comb begin
      strobe = '0;
      for (int i = 0; i < NUM_BULBS; i++) begin
         strobe[i] = (state_q == ST_SAMPLE) && (sel_q == SEL_W'(i));
      end
   end

   for (genvar gi = 0; gi < NUM_BULBS; gi++) begin : g_bulb
      bulb_debounce #(
         .FAIL_CNT    (FAIL_CNT),
         .RECOVER_CNT (RECOVER_CNT)
      ) u_debounce (
         .clk      (clk),
         .rst      (rst),
         .sample_i (strobe[gi]),
         .value_i  (sense_s_q),
         .status_o (status_vec[gi]),
         .fall_o   (fall_vec[gi])
      );
   end

   // At most one bulb is evaluated per sample, so the fall pulses never overlap.
   assign fault_pulse  = |fall_vec;
   assign bulb_status  = status_vec;
   assign sense_sel    = sel_q;
   assign status_valid = valid_q;

endmodule

// File: tb/tb_bulb_health_monitor.sv
module tb_bulb_health_monitor;
   import chandelier_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sense_ok = 1'b0;
   logic [1:0]   sense_sel;
   bulb_status_t bulb_status;
   logic         status_valid;
   logic         fault_pulse;

   bulb_health_monitor #(
      .SETTLE_CYC  (4),
      .FAIL_CNT    (3),
      .RECOVER_CNT (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sense_ok     (sense_ok),
      .sense_sel    (sense_sel),
      .bulb_status  (bulb_status),
      .status_valid (status_valid),
      .fault_pulse  (fault_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] status;
      logic       pulse;
      logic       valid;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         k_since_rst = 0;
   logic [1:0] cur_bulb = 2'd0;
   logic [1:0] prev_sel = 2'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // One bulb slot: drive the comparator, queue what the DUT must show
   // right after this slot's sample, then wait out the slot.
   task automatic slot(input logic ok, input logic [3:0] st, input logic pl, input bit glitch);
      exp_t e;
      e.sel    = cur_bulb + 2'd1;
      e.status = st;
      e.pulse  = pl;
      e.valid  = (k_since_rst >= 3);
      exp_q.push_back(e);
      if (glitch) begin
         int n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            #($urandom_range(0, 3));
            sense_ok = ~sense_ok;
         end
      end
      sense_ok = ok;
      cur_bulb++;
      k_since_rst++;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sel",    32'(sense_sel),    32'd0);
      check("rst_status", 32'(bulb_status),  32'hF);
      check("rst_valid",  32'(status_valid), 32'd0);
      check("rst_pulse",  32'(fault_pulse),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      cur_bulb    = 2'd0;
      k_since_rst = 0;
   endtask

   // Monitor: a sense_sel step marks the cycle after a sample.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_sel = sense_sel;
      end else if (sense_sel != prev_sel) begin
         if (exp_q.size() == 0) begin
            check("unexpected_sample", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sel",    32'(sense_sel),    32'(e.sel));
            check("status", 32'(bulb_status),  32'(e.status));
            check("pulse",  32'(fault_pulse),  32'(e.pulse));
            check("valid",  32'(status_valid), 32'(e.valid));
         end
         prev_sel = sense_sel;
      end else begin
         check("idle_pulse", 32'(fault_pulse), 32'd0);
         check("no_x", 32'($isunknown({sense_sel, bulb_status, status_valid, fault_pulse})), 32'd0);
      end
   end

   initial begin
      logic [3:0] st;
      logic [5:0] pat;
      logic       ok;
      pat = 6'b100100;

      do_reset();

      // A: all bulbs good.
      for (int k = 0; k < 8; k++) slot(1'b1, 4'hF, 1'b0, 1'b0);

      // B: bulb 2 reads bad; fails on its 3rd sample.
      for (int s = 1; s <= 4; s++)
         for (int b = 0; b < 4; b++) begin
            st = (s > 3 || (s == 3 && b >= 2)) ? 4'b1011 : 4'b1111;
            slot(b != 2, st, (s == 3 && b == 2), 1'b0);
         end

      // C: bulb 1 glitches bad 2 scans, good 1, bad 2, good 1: never fails.
      for (int s = 0; s < 6; s++)
         for (int b = 0; b < 4; b++) begin
            ok = (b == 1) ? pat[s] : (b != 2);
            slot(ok, 4'b1011, 1'b0, 1'b0);
         end

      // D: bulb 2 restored; recovers on 3rd good sample without a pulse.
      for (int s = 1; s <= 3; s++)
         for (int b = 0; b < 4; b++) begin
            st = (s == 3 && b >= 2) ? 4'b1111 : 4'b1011;
            slot(1'b1, st, 1'b0, 1'b0);
         end

      // E: bulb 0 fails, then collects 2 good samples toward recovery.
      for (int s = 1; s <= 5; s++)
         for (int b = 0; b < 4; b++) begin
            if (!(s == 5 && b == 3)) begin
               st = (s >= 3) ? 4'b1110 : 4'b1111;
               slot((b != 0) || (s > 3), st, (s == 3 && b == 0), 1'b0);
            end
         end

      // Asynchronous reset in the middle of bulb 3's settle time.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_sel",    32'(sense_sel),    32'd0);
      check("arst_status", 32'(bulb_status),  32'hF);
      check("arst_valid",  32'(status_valid), 32'd0);
      check("arst_pulse",  32'(fault_pulse),  32'd0);
      check("arst_queue",  32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cur_bulb    = 2'd0;
      k_since_rst = 0;

      // F: bulb 0 needs three fresh bad samples after reset.
      for (int s = 1; s <= 3; s++)
         for (int b = 0; b < 4; b++) begin
            st = (s == 3) ? 4'b1110 : 4'b1111;
            slot(b != 0, st, (s == 3 && b == 0), 1'b0);
         end

      // G: glitching comparator; bulb 0 recovers, bulb 3 fails.
      for (int s = 1; s <= 4; s++)
         for (int b = 0; b < 4; b++) begin
            if (s < 3)       st = 4'b1110;
            else if (s == 3) st = (b < 3) ? 4'b1111 : 4'b0111;
            else             st = 4'b0111;
            slot(b != 3, st, (s == 3 && b == 3), 1'b1);
         end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bulb_health_monitor.md
# bulb_health_monitor

Sensing front end that produces the 4-bit `bulb_status` word consumed by the chandelier brightness controller. A single shared current-sense comparator is time-multiplexed across the four bulbs. For each bulb the block selects it, waits for the sense path to settle, samples, and debounces the result over consecutive scans. It then publishes a stable working/faulty flag per bulb, plus a fault-event pulse and a scan-valid flag.

## Interface
- `SETTLE_CYC`, default 4: cycles between selecting a bulb and sampling it. Legal range 3..15; must cover the 2-flop synchronizer.
- `FAIL_CNT`, default 3: consecutive bad samples needed to declare a working bulb faulty (1..7).
- `RECOVER_CNT`, default 3: consecutive good samples needed to declare a faulty bulb working (1..7).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sense_ok` in 1: raw comparator output, asynchronous to `clk`. 1 means current is flowing through the selected bulb.
- `sense_sel` out 2: index of the bulb currently routed to the comparator.
- `bulb_status` out 4: bit i is 1 when bulb i is working, 0 when faulty. Feeds the brightness controller.
- `status_valid` out 1: goes high once the first complete 4-bulb scan is done, then stays high until reset.
- `fault_pulse` out 1: one-cycle pulse when any `bulb_status` bit falls from 1 to 0.

## Operation
- `sense_ok` passes through a 2-flop synchronizer (`sense_s`) before any use.
- FSM with two states:
  - SETTLE: `settle_cnt` counts 0..SETTLE_CYC-1. At SETTLE_CYC-1 the FSM moves to SAMPLE.
  - SAMPLE: lasts one cycle and consumes `sense_s` for bulb `sense_sel`. Then `sense_sel` increments mod 4 (3 wraps to 0), `settle_cnt` clears, and the FSM returns to SETTLE.
- Each bulb has a 3-bit run counter `run[i]`.
- Sample that agrees with the current `bulb_status[i]`:
  - `run[i]` clears to 0.
- Sample that disagrees:
  - `run[i]` increments.
  - On reaching the threshold (FAIL_CNT when the bulb is currently working, RECOVER_CNT when faulty), `bulb_status[i]` toggles and `run[i]` clears.
  - `run[i]` never exceeds its threshold.
- `fault_pulse` asserts in the cycle after the SAMPLE that cleared a status bit. Only one bulb is evaluated per SAMPLE, so simultaneous faults cannot occur; no queuing is needed.
- `status_valid` sets in the cycle after the SAMPLE of bulb 3 on the first scan.
- Reset values:
  - FSM in SETTLE, `settle_cnt`=0, `sense_sel`=0, all `run`=0.
  - `bulb_status`=4'b1111 (bulbs assumed working, so the controller sits at default brightness).
  - `status_valid`=0, `fault_pulse`=0, synchronizer flops=0.
- Reset mid-scan discards all partial debounce history immediately (asynchronous).

## Timing
- Per-bulb slot: SETTLE_CYC+1 cycles. Full scan: 4*(SETTLE_CYC+1) cycles. With defaults, 5 and 20.
- With defaults, the first SAMPLE occurs in cycle 4 after reset release. The first `status_valid`=1 is visible in cycle 20.
- `sense_sel` changes on the clock edge that ends SAMPLE and stays stable for the whole slot.
- Fault detection latency after a bulb physically opens: at most FAIL_CNT full scans plus one slot plus 2 synchronizer cycles.
- All outputs are registered; no combinational path from `sense_ok`.

## Structure
- Package `chandelier_pkg`: `NUM_BULBS`=4, state enum {ST_SETTLE, ST_SAMPLE}, and the `bulb_status` word typedef shared with the brightness controller.
- One natural sub-module, `bulb_debounce`, one instance per bulb, generated 4 times:
  - Inputs: sample strobe and sampled value.
  - Outputs: status bit and fall pulse.
  - Holds `run[i]` and the threshold logic.
- The top level holds the synchronizer, FSM, `sense_sel` counter, `status_valid`, and the OR of the fall pulses into `fault_pulse`.

## Test plan
- Reset, then `sense_ok`=1 constantly:
  - `sense_sel` steps 0,1,2,3,0 every 5 cycles.
  - `bulb_status`=4'b1111 throughout.
  - `status_valid` rises at cycle 20.
  - `fault_pulse` never asserts.
- `sense_ok`=0 only while `sense_sel`=2:
  - `bulb_status` becomes 4'b1011 after the 3rd bulb-2 sample.
  - Exactly one `fault_pulse`.
  - The other bits stay 1.
- Bulb 1 glitches bad for 2 scans, then good:
  - `bulb_status` stays 4'b1111 and `run[1]` returns to 0.
  - With FAIL_CNT=3, no pulse.
- Faulty bulb 2 restored:
  - Bit 2 returns to 1 after 3 consecutive good samples.
  - No `fault_pulse` on the rising edge of the bit.
- Assert `rst` mid-SETTLE of bulb 3, with bulb 0 at `run`=2 and bit 0 faulty:
  - All outputs return to their reset values asynchronously.
  - After release, scanning restarts at bulb 0.
  - Bulb 0 needs 3 fresh bad samples to fail again.
- Toggle `sense_ok` asynchronously near clock edges (random phase):
  - No X on any output.
  - Status decisions match the synchronized model.
